mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles to wait for m_ack before aborting (legal range 2..255).
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low; 0 at a rising clk edge resets the block.
REQ-004 i_req  input  1  instruction-fetch request, held until i_gnt.
REQ-005 i_addr  input  32  fetch address, sampled when i_gnt=1.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  one-cycle pulse, fetch complete.
REQ-008 i_rdata  output  32  fetched word, valid while i_rvalid=1.
REQ-009 i_err  output  1  with i_rvalid: fetch timed out.
REQ-010 d_req, d_addr, d_we, d_wdata  input  1/32/1/32  load/store request, address, write enable, store data; held until d_gnt.
REQ-011 d_gnt, d_rvalid, d_rdata, d_err  output  1/1/32/1  data-port equivalents of i_gnt, i_rvalid, i_rdata, i_err.
REQ-012 m_req, m_addr, m_we, m_wdata  output  1/32/1/32  request to memory controller.
REQ-013 m_rdata  input  32  read data, valid with m_ack.
REQ-014 m_ack  input  1  memory transaction complete, at most one per m_req.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY_I and BUSY_D, and one transaction outstanding at most.
REQ-016 In IDLE with only one request, that port SHALL be granted; with both, the port not recorded in last_served SHALL be granted (round-robin).
REQ-017 x_gnt SHALL be combinational and asserted only in IDLE, for the selected port, in the same cycle as its x_req.
REQ-018 On grant, address, write enable (0 for the instruction port) and write data SHALL be registered, and the FSM SHALL enter BUSY_x next cycle with last_served=x.
REQ-019 In BUSY_x, m_req SHALL be 1, and m_addr/m_we/m_wdata SHALL stay stable until m_ack or timeout.
REQ-020 On m_ack in BUSY_x, the FSM SHALL return to IDLE, and the next cycle SHALL give x_rvalid=1, x_err=0 and x_rdata=m_rdata (writes: x_rdata=0).
REQ-021 m_req SHALL deassert the cycle after m_ack; m_ack while IDLE SHALL be ignored.
REQ-022 Minimum latency SHALL be: grant at cycle 0, m_req at 1, m_ack at 1 or later, x_rvalid one cycle after m_ack.
REQ-023 IDLE SHALL be able to grant in the same cycle that x_rvalid pulses, giving back-to-back service.
REQ-024 A watchdog counter SHALL clear on entry to BUSY_x and increment each BUSY cycle without m_ack.
REQ-025 When the counter reaches TIMEOUT-1 without m_ack, the FSM SHALL return to IDLE, and the next cycle SHALL give x_rvalid=1, x_err=1 and x_rdata=32'hDEADBEEF.
REQ-026 m_ack arriving in the same cycle as the timeout SHALL win: normal completion, err=0.
REQ-027 x_rdata SHALL hold its last value between rvalid pulses.
REQ-028 A request dropped before grant SHALL be ignored.

Reset
REQ-029 While reset=0: state SHALL be IDLE, last_served=I (so D wins the first tie), counter=0, and every output, including m_addr/m_wdata/rdata, SHALL be 0.
REQ-030 Reset mid-transaction SHALL abandon it with no rvalid, and a later stale m_ack SHALL be ignored.
REQ-031 Requests SHALL be granted starting from the first edge with reset=1.

Verification
REQ-032 After reset, i_req=1 and i_addr=0x80000004; m_ack on the 2nd BUSY cycle with m_rdata=0x00100093 -> i_gnt cycle 0, m_req cycles 1-2, i_rvalid cycle 3 with i_rdata=0x00100093 and i_err=0.
REQ-033 After reset, i_req and d_req both held -> D granted first, then I, then D, alternating; no port starves.
REQ-034 Store: d_we=1, d_addr=0x80000010, d_wdata=0xCAFEBABE -> m_we=1 with stable values until m_ack; d_rvalid=1 with d_rdata=0.
REQ-035 No m_ack with TIMEOUT=16 -> m_req high for exactly 16 cycles, then d_rvalid=1, d_err=1, d_rdata=0xDEADBEEF.
REQ-036 reset=0 in the 2nd BUSY cycle, then m_ack 2 cycles later -> no rvalid; outputs stay 0; the next request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin instruction/data arbiter onto a single memory port
// One transaction in flight; a watchdog turns a missing m_ack into an error response.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_req,
   output logic [31:0] m_addr,
   output logic        m_we,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   localparam logic [7:0]  TIMEOUT_M1 = 8'(TIMEOUT - 1);
   localparam logic [31:0] ERR_WORD   = 32'hDEADBEEF;

   state_t      state_q, state_d;
   logic        last_d_q, last_d_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] m_addr_q, m_addr_d;
   logic        m_we_q, m_we_d;
   logic [31:0] m_wdata_q, m_wdata_d;
   logic        i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        gnt_i, gnt_d;
   logic [31:0] resp_data;

   // On a tie the port that was not served last wins.
   assign gnt_i = (state_q == IDLE) && i_req && (!d_req || last_d_q);
   assign gnt_d = (state_q == IDLE) && d_req && (!i_req || !last_d_q);
   assign resp_data = m_we_q ? 32'd0 : m_rdata;

   always_comb begin
      state_d    = state_q;
      last_d_d   = last_d_q;
      cnt_d      = cnt_q;
      m_addr_d   = m_addr_q;
      m_we_d     = m_we_q;
      m_wdata_d  = m_wdata_q;
      i_rvalid_d = 1'b0;
      i_err_d    = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rvalid_d = 1'b0;
      d_err_d    = 1'b0;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (gnt_d) begin
               state_d   = BUSY_D;
               last_d_d  = 1'b1;
               cnt_d     = 8'd0;
               m_addr_d  = d_addr;
               m_we_d    = d_we;
               m_wdata_d = d_wdata;
            end else if (gnt_i) begin
               state_d   = BUSY_I;
               last_d_d  = 1'b0;
               cnt_d     = 8'd0;
               m_addr_d  = i_addr;
               m_we_d    = 1'b0;
               m_wdata_d = 32'd0;
            end
         end
         BUSY_I: begin
            if (m_ack) begin
               state_d    = IDLE;
               i_rvalid_d = 1'b1;
               i_rdata_d  = resp_data;
            end else if (cnt_q == TIMEOUT_M1) begin
               state_d    = IDLE;
               i_rvalid_d = 1'b1;
               i_err_d    = 1'b1;
               i_rdata_d  = ERR_WORD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         BUSY_D: begin
            if (m_ack) begin
               state_d    = IDLE;
               d_rvalid_d = 1'b1;
               d_rdata_d  = resp_data;
            end else if (cnt_q == TIMEOUT_M1) begin
               state_d    = IDLE;
               d_rvalid_d = 1'b1;
               d_err_d    = 1'b1;
               d_rdata_d  = ERR_WORD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_d_q   <= 1'b0;
         cnt_q      <= 8'd0;
         m_addr_q   <= 32'd0;
         m_we_q     <= 1'b0;
         m_wdata_q  <= 32'd0;
         i_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         i_rdata_q  <= 32'd0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         last_d_q   <= last_d_d;
         cnt_q      <= cnt_d;
         m_addr_q   <= m_addr_d;
         m_we_q     <= m_we_d;
         m_wdata_q  <= m_wdata_d;
         i_rvalid_q <= i_rvalid_d;
         i_err_q    <= i_err_d;
         i_rdata_q  <= i_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Outputs are forced low while reset is held, including before the first edge.
   assign i_gnt    = reset & gnt_i;
   assign d_gnt    = reset & gnt_d;
   assign m_req    = reset & (state_q != IDLE);
   assign m_addr   = reset ? m_addr_q : 32'd0;
   assign m_we     = reset & m_we_q;
   assign m_wdata  = reset ? m_wdata_q : 32'd0;
   assign i_rvalid = reset & i_rvalid_q;
   assign i_err    = reset & i_err_q;
   assign i_rdata  = reset ? i_rdata_q : 32'd0;
   assign d_rvalid = reset & d_rvalid_q;
   assign d_err    = reset & d_err_q;
   assign d_rdata  = reset ? d_rdata_q : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
// Transaction-level model: round-robin winner, response latency and response word per request.
module tb_mem_arbiter;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, m_ack;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [135:0] all_out;

   int checks = 0;
   int errors = 0;

   // Model state: which port was served last, and last response word per port.
   bit          mdl_last_d;
   logic [31:0] mdl_i_rdata, mdl_d_rdata;

   mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   assign all_out = {i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
                     m_req, m_addr, m_we, m_wdata};

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic model_reset();
      mdl_last_d  = 1'b0;
      mdl_i_rdata = 32'd0;
      mdl_d_rdata = 32'd0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic run_txn(input bit ri, input bit rd, input logic [31:0] ia,
                          input logic [31:0] da, input bit dwe, input logic [31:0] dw,
                          input logic [31:0] rdat, input int delay);
      bit          win_d, to;
      logic [31:0] e_addr, e_rdata;
      bit          e_we;
      int          last_k, nreq;
      win_d   = rd && (!ri || !mdl_last_d);
      to      = (delay > TIMEOUT);
      last_k  = to ? TIMEOUT : delay;
      e_addr  = win_d ? da : ia;
      e_we    = win_d ? dwe : 1'b0;
      e_rdata = to ? 32'hDEADBEEF : (e_we ? 32'd0 : rdat);
      nreq    = 0;

      @(posedge clk); #1;
      i_req = ri; i_addr = ia; d_req = rd; d_addr = da; d_we = dwe; d_wdata = dw;
      m_ack = 1'($urandom % 2); m_rdata = $urandom;
      @(negedge clk);
      checks++;
      if ({i_gnt, d_gnt, m_req} !== {!win_d, win_d, 1'b0}) begin
         errors++;
         $display("FAIL grant: i_gnt=%0b d_gnt=%0b m_req=%0b, want %0b %0b 0",
                  i_gnt, d_gnt, m_req, !win_d, win_d);
      end

      for (int k = 1; k <= last_k; k++) begin
         @(posedge clk); #1;
         i_req = 1'b0; d_req = 1'b0;
         i_addr = $urandom; d_addr = $urandom; d_we = 1'($urandom % 2); d_wdata = $urandom;
         m_ack = (k == delay); m_rdata = (k == delay) ? rdat : $urandom;
         @(negedge clk);
         if (m_req === 1'b1) nreq++;
         checks++;
         if (m_req !== 1'b1 || m_addr !== e_addr || m_we !== e_we || (win_d && m_wdata !== dw)) begin
            errors++;
            $display("FAIL busy_cycle%0d: m_req=%0b m_addr=%h m_we=%0b m_wdata=%h, want 1 %h %0b %h",
                     k, m_req, m_addr, m_we, m_wdata, e_addr, e_we, dw);
         end
         checks++;
         if (i_rvalid || d_rvalid || i_gnt || d_gnt || i_rdata !== mdl_i_rdata || d_rdata !== mdl_d_rdata) begin
            errors++;
            $display("FAIL hold: rvalid=%0b%0b gnt=%0b%0b i_rdata=%h d_rdata=%h, want 00 00 %h %h",
                     i_rvalid, d_rvalid, i_gnt, d_gnt, i_rdata, d_rdata, mdl_i_rdata, mdl_d_rdata);
         end
      end
      checks++;
      if (nreq != last_k) begin
         errors++;
         $display("FAIL m_req_cycles: got %0d, want %0d", nreq, last_k);
      end

      @(posedge clk); #1;
      m_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (win_d) begin
         if ({d_rvalid, d_err, d_rdata, i_rvalid, m_req} !== {1'b1, to, e_rdata, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL d_resp: d_rvalid=%0b d_err=%0b d_rdata=%h i_rvalid=%0b m_req=%0b, want 1 %0b %h 0 0",
                     d_rvalid, d_err, d_rdata, i_rvalid, m_req, to, e_rdata);
         end
         mdl_d_rdata = e_rdata;
      end else begin
         if ({i_rvalid, i_err, i_rdata, d_rvalid, m_req} !== {1'b1, to, e_rdata, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL i_resp: i_rvalid=%0b i_err=%0b i_rdata=%h d_rvalid=%0b m_req=%0b, want 1 %0b %h 0 0",
                     i_rvalid, i_err, i_rdata, d_rvalid, m_req, to, e_rdata);
         end
         mdl_i_rdata = e_rdata;
      end
      mdl_last_d = win_d;
   endtask

   task automatic test_reset();
      reset = 1'b0; i_req = 1'b1; d_req = 1'b1; m_ack = 1'b1;
      i_addr = $urandom; d_addr = $urandom; d_we = 1'b1; d_wdata = $urandom; m_rdata = $urandom;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want 0", all_out);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h, want 0", all_out);
      end
   endtask

   task automatic test_basic_fetch();
      run_txn(1'b1, 1'b0, 32'h80000004, 32'd0, 1'b0, 32'd0, 32'h00100093, 2);
   endtask

   task automatic test_back_to_back();
      do_reset();
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      i_addr = 32'h00001000; d_addr = 32'h00002000;
      for (int n = 0; n < 6; n++) begin
         bit win_d;
         win_d = (n % 2 == 0);
         @(negedge clk);
         checks++;
         if ({i_gnt, d_gnt} !== {!win_d, win_d} ||
             (n > 0 && {i_rvalid, d_rvalid} !== {win_d, !win_d})) begin
            errors++;
            $display("FAIL rr_grant%0d: gnt=%0b%0b rvalid=%0b%0b, want gnt=%0b%0b", n,
                     i_gnt, d_gnt, i_rvalid, d_rvalid, !win_d, win_d);
         end
         @(posedge clk); #1;
         m_ack = 1'b1; m_rdata = 32'(n);
         @(negedge clk);
         checks++;
         if (m_req !== 1'b1 || m_addr !== (win_d ? d_addr : i_addr)) begin
            errors++;
            $display("FAIL rr_busy%0d: m_req=%0b m_addr=%h", n, m_req, m_addr);
         end
         @(posedge clk); #1;
         m_ack = 1'b0;
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({i_rvalid, d_rvalid, i_rdata, i_gnt, d_gnt} !== {1'b1, 1'b0, 32'd5, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL rr_last: i_rvalid=%0b d_rvalid=%0b i_rdata=%h gnt=%0b%0b, want 1 0 5 00",
                  i_rvalid, d_rvalid, i_rdata, i_gnt, d_gnt);
      end
      mdl_last_d  = 1'b0;
      mdl_i_rdata = 32'd5;
      mdl_d_rdata = 32'd4;
   endtask

   task automatic test_store();
      run_txn(1'b0, 1'b1, 32'd0, 32'h80000010, 1'b1, 32'hCAFEBABE, 32'h12345678, 3);
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 1'b1, 32'd0, 32'h80000020, 1'b0, 32'd0, 32'h0, 100);
      run_txn(1'b1, 1'b0, 32'h80000024, 32'd0, 1'b0, 32'd0, 32'h0BADF00D, TIMEOUT);
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      d_req = 1'b1; d_addr = 32'h80000030; d_we = 1'b0; d_wdata = 32'd0;
      @(negedge clk);
      checks++;
      if (d_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_grant: d_gnt=%0b, want 1", d_gnt);
      end
      @(posedge clk); #1;
      d_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin
            @(posedge clk); #1;
         end else if (c == 2) begin
            @(posedge clk); #1;
            reset = 1'b1; m_ack = 1'b1; m_rdata = 32'h55AA55AA;
         end else if (c == 3) begin
            @(posedge clk); #1;
            m_ack = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL mid_reset%0d: got %h, want 0", c, all_out);
         end
      end
      model_reset();
      run_txn(1'b1, 1'b0, 32'h80000040, 32'd0, 1'b0, 32'd0, 32'hA5A5A5A5, 1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         bit ri, rd;
         ri = 1'($urandom % 2);
         rd = 1'($urandom % 2);
         if (!ri && !rd) ri = 1'b1;
         run_txn(ri, rd, $urandom, $urandom, 1'($urandom % 2), $urandom, $urandom,
                 int'($urandom_range(1, TIMEOUT + 2)));
      end
   endtask

   initial begin
      reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
      i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; m_rdata = 32'd0;
      model_reset();
      test_reset();
      test_basic_fetch();
      test_back_to_back();
      test_store();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
